// File: rtl/mips_board_pkg.sv
// Shared board-level constants: run-mode encodings and a small sizing helper.
package mips_board_pkg;

  // Run modes, encoded exactly as the two mode switches read.
  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  localparam int STEP_CNT_W = 16;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, then a debouncer whose level
// only follows the synchronized input after DEBOUNCE_CYCLES consecutive
// disagreeing cycles. rise_o is a registered one-cycle pulse that fires in the
// same cycle level_o goes high.
module btn_debounce
  import mips_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Two-stage synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for a board-hosted MIPS core. Produces a single-cycle clock
// enable (cpu_ce) in HALT / RUN (divided) / STEP (button) / FAST (every cycle)
// modes, counts issued enables, and mirrors one LED-wide slice of the CPU
// debug word. Everything runs on clk; there are no derived clocks.
// Pulse decisions use the incoming state, so a mode change landing on a
// divider wrap or a button edge follows the new mode.
module mips_run_ctrl
  import mips_board_pkg::*;
#(
  parameter  int CLK_HZ          = 125000000,
  parameter  int STEP_HZ         = 1,
  parameter  int DEBOUNCE_CYCLES = 1250000,
  parameter  int DATA_W          = 32,
  parameter  int LED_W           = 4,
  localparam int N_SLICE         = DATA_W / LED_W,
  localparam int SEL_W           = clog2_min1(N_SLICE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            sw_mode,
  input  logic                  btn_step,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DATA_W-1:0]     cpu_out,
  output logic                  cpu_ce,
  output logic [LED_W-1:0]      led,
  output logic [STEP_CNT_W-1:0] step_cnt,
  output logic [1:0]            state_dbg,
  output logic                  btn_level_dbg
);

  localparam int DIV_RAW = (STEP_HZ > 0) ? CLK_HZ / STEP_HZ : 1;
  localparam int DIV     = (DIV_RAW > 1) ? DIV_RAW : 1;
  localparam int DIV_W   = clog2_min1(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [1:0]            mode_s1_q, mode_s2_q;
  mode_e                 state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  cpu_ce_q, cpu_ce_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic                  btn_level, btn_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_step),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  // Two-stage synchronizer for the mode switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_s1_q <= 2'b00;
      mode_s2_q <= 2'b00;
    end else begin
      mode_s1_q <= sw_mode;
      mode_s2_q <= mode_s1_q;
    end
  end

  // Mode FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MODE_HALT;
    else       state_q <= state_d;
  end

  // Next state is simply the synchronized switch setting; pulse generation
  // keys off that next state so the old mode never issues a late pulse.
  always_comb begin
    state_d  = mode_e'(mode_s2_q);
    div_d    = '0;
    cpu_ce_d = 1'b0;
    unique case (state_d)
      MODE_RUN: begin
        if (state_q != MODE_RUN) begin
          div_d = '0;
        end else if (div_q == DIV_LAST) begin
          cpu_ce_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      MODE_STEP: cpu_ce_d = btn_rise;
      MODE_FAST: cpu_ce_d = 1'b1;
      default:   cpu_ce_d = 1'b0;
    endcase
    step_cnt_d = step_cnt_q + STEP_CNT_W'(cpu_ce_d);
  end

  // LED slice mux; out-of-range selects fall back to slice 0.
  always_comb begin
    led_d = cpu_out[LED_W-1:0];
    for (int i = 0; i < N_SLICE; i++) begin
      if (sel == SEL_W'(i)) led_d = cpu_out[i*LED_W +: LED_W];
    end
  end

  // Divider, enable, pulse counter and LED output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      cpu_ce_q   <= 1'b0;
      step_cnt_q <= '0;
      led_q      <= '0;
    end else begin
      div_q      <= div_d;
      cpu_ce_q   <= cpu_ce_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
    end
  end

  assign cpu_ce        = cpu_ce_q;
  assign led           = led_q;
  assign step_cnt      = step_cnt_q;
  assign state_dbg     = state_q;
  assign btn_level_dbg = btn_level;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl with DIV=10, DEBOUNCE=4, 32-bit data, 4 LEDs.
// A history-based model predicts each cycle's outputs into exp_q; a compare
// process checks them on every falling edge. Directed sections add literal
// expectations on pulse timing and counts.
module tb_mips_run_ctrl;
  import mips_board_pkg::*;

  localparam int DIV = 10;
  localparam int DB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sw_mode = 2'b00;
  logic        btn_step = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [31:0] cpu_out = 32'd0;
  logic        cpu_ce;
  logic [3:0]  led;
  logic [15:0] step_cnt;
  logic [1:0]  state_dbg;
  logic        btn_level_dbg;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  // Expected word: {level, state[1:0], ce, step_cnt[15:0], led[3:0]}
  logic [23:0] exp_q[$];
  logic [1:0]  sw_h[$];
  logic        btn_h[$];
  int          ce_seen[$];

  logic        m_level, m_rise, m_ce, m_all_diff;
  logic [1:0]  m_mode, m_prev;
  logic [15:0] m_cnt;
  logic [3:0]  m_led;
  int          m_run_e, m_k;
  logic [23:0] cmp_exp;

  mips_run_ctrl #(
    .CLK_HZ(100), .STEP_HZ(10), .DEBOUNCE_CYCLES(DB), .DATA_W(32), .LED_W(4)
  ) dut (
    .clk(clk), .reset(reset), .sw_mode(sw_mode), .btn_step(btn_step),
    .sel(sel), .cpu_out(cpu_out), .cpu_ce(cpu_ce), .led(led),
    .step_cnt(step_cnt), .state_dbg(state_dbg), .btn_level_dbg(btn_level_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sw_at(input int i);
    if (i < 0 || i >= sw_h.size()) return 2'b00;
    return sw_h[i];
  endfunction

  function automatic logic btn_at(input int i);
    if (i < 0 || i >= btn_h.size()) return 1'b0;
    return btn_h[i];
  endfunction

  // ---------------- behavioural model ----------------
  // Edge k (counted from reset release): the mode in force is the switch value
  // seen two edges earlier; the debounced level toggles once the last DB
  // synchronized samples all disagree with it; a rise arms one STEP pulse for
  // the next edge; RUN pulses every DIV edges after entry; FAST pulses always.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete(); sw_h.delete(); btn_h.delete();
      m_level = 1'b0; m_rise = 1'b0; m_cnt = 16'd0; m_run_e = 0;
    end else begin
      sw_h.push_back(sw_mode);
      btn_h.push_back(btn_step);
      m_k    = sw_h.size() - 1;
      m_mode = sw_at(m_k - 2);
      m_prev = sw_at(m_k - 3);
      m_ce   = 1'b0;
      case (m_mode)
        MODE_FAST: m_ce = 1'b1;
        MODE_STEP: m_ce = m_rise;
        MODE_RUN: begin
          if (m_prev != MODE_RUN) m_run_e = m_k;
          else m_ce = ((m_k - m_run_e) % DIV) == 0;
        end
        default: m_ce = 1'b0;
      endcase
      m_all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (btn_at(m_k - j) == m_level) m_all_diff = 1'b0;
      m_rise = m_all_diff && !m_level;
      if (m_all_diff) m_level = ~m_level;
      m_cnt = m_cnt + 16'(m_ce);
      m_led = cpu_out[sel*4 +: 4];
      exp_q.push_back({m_level, m_mode, m_ce, m_cnt, m_led});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    #1;
    if (reset) begin
      chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_step_cnt", 32'(step_cnt), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      chk("rst_level", 32'(btn_level_dbg), 32'd0);
    end else begin
      cmp_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'd0;
      chk("cpu_ce", 32'(cpu_ce), 32'(cmp_exp[20]));
      chk("step_cnt", 32'(step_cnt), 32'(cmp_exp[19:4]));
      chk("led", 32'(led), 32'(cmp_exp[3:0]));
      chk("state", 32'(state_dbg), 32'(cmp_exp[22:21]));
      chk("btn_level", 32'(btn_level_dbg), 32'(cmp_exp[23]));
      if (cpu_ce) ce_seen.push_back(ecnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset = 1'b1; sw_mode = m; btn_step = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int  d, d2;
  logic found;

  initial begin
    tick(3);
    reset = 1'b0;

    // RUN held from reset: pulses at +13, +23 ... relative to the drive point.
    d = ecnt; ce_seen.delete();
    cpu_out = 32'h87654321; sel = 3'd5; sw_mode = MODE_RUN;
    tick(53);
    chk("run_npulse", 32'(ce_seen.size()), 32'd5);
    if (ce_seen.size() >= 5) begin
      chk("run_first", 32'(ce_seen[0] - d), 32'd13);
      chk("run_span", 32'(ce_seen[4] - ce_seen[0]), 32'd40);
    end
    chk("run_cnt5", 32'(step_cnt), 32'd5);

    // Asynchronous reset right after the sixth pulse.
    tick(9);
    @(posedge clk); #2;
    chk("pre_rst_ce", 32'(cpu_ce), 32'd1);
    chk("pre_rst_cnt", 32'(step_cnt), 32'd6);
    chk("pre_rst_led", 32'(led), 32'd6);
    reset = 1'b1;
    #1;
    chk("async_ce", 32'(cpu_ce), 32'd0);
    chk("async_cnt", 32'(step_cnt), 32'd0);
    chk("async_led", 32'(led), 32'd0);
    tick(2);
    reset = 1'b0;
    d = ecnt; ce_seen.delete();
    tick(14);
    chk("run_after_rst", (ce_seen.size() > 0) ? 32'(ce_seen[0] - d) : 32'hFFFF, 32'd13);

    // Mode drops to HALT exactly on the would-be second wrap; re-entry is a full period.
    sw_mode = MODE_HALT; tick(5);
    d = ecnt; ce_seen.delete(); sw_mode = MODE_RUN;
    tick(20);
    sw_mode = MODE_HALT;
    tick(10);
    chk("halt_wrap_n", 32'(ce_seen.size()), 32'd1);
    if (ce_seen.size() >= 1) chk("halt_wrap_t", 32'(ce_seen[0] - d), 32'd13);
    d2 = ecnt; ce_seen.delete(); sw_mode = MODE_RUN;
    tick(13);
    chk("reentry_n", 32'(ce_seen.size()), 32'd1);
    if (ce_seen.size() >= 1) chk("reentry_t", 32'(ce_seen[0] - d2), 32'd13);

    // STEP: one long press gives one pulse, 7 cycles after the raw edge.
    do_reset(MODE_STEP);
    d = ecnt; ce_seen.delete(); btn_step = 1'b1;
    tick(20);
    btn_step = 1'b0;
    tick(10);
    chk("step_n", 32'(ce_seen.size()), 32'd1);
    if (ce_seen.size() >= 1) chk("step_t", 32'(ce_seen[0] - d), 32'd7);
    chk("step_cnt1", 32'(step_cnt), 32'd1);

    // Bouncing button: never stable long enough.
    ce_seen.delete();
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1; tick(2);
      btn_step = 1'b0; tick(2);
    end
    tick(15);
    chk("bounce_n", 32'(ce_seen.size()), 32'd0);

    // Press completed in HALT is discarded, not replayed on entering STEP.
    sw_mode = MODE_HALT; tick(4);
    ce_seen.delete(); btn_step = 1'b1;
    tick(12);
    sw_mode = MODE_STEP;
    tick(10);
    btn_step = 1'b0;
    tick(10);
    chk("halt_press_n", 32'(ce_seen.size()), 32'd0);
    chk("halt_press_cnt", 32'(step_cnt), 32'd1);

    // FAST with LED slice walk.
    do_reset(MODE_FAST);
    cpu_out = 32'h87654321; sel = 3'd0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick(1);
      chk("led_slice", 32'(led), 32'(i + 1));
      chk("fast_ce", 32'(cpu_ce), 32'd1);
    end

    // Counter wrap 0xFFFF -> 0x0000.
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      tick(1);
      if (step_cnt == 16'hFFFF) found = 1'b1;
    end
    chk("wrap_reached", 32'(found), 32'd1);
    tick(1);
    chk("wrap_zero", 32'(step_cnt), 32'd0);

    sw_mode = MODE_HALT;
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
